shc_varlat_adder: RTL and testbench

//  Parametrised variable-latency speculative Han-Carlson adder with registered handshake.

---
 rtl/shc_pkg.sv | 27 ++
 rtl/shc_spec_prefix.sv | 80 ++++++++
 rtl/shc_varlat_adder.sv | 147 ++++++++++++++
 tb/tb_shc_varlat_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shc_pkg.sv
// Shared types and prefix-cell helpers for the speculative Han-Carlson adder.
package shc_pkg;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_CORR, S_HOLD} state_t;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int spec_window(input int levels);
    return 1 << levels;
  endfunction

  // Combine a more-significant group (hi) with the adjacent less-significant group (lo).
  function automatic gp_t black_cell(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic logic grey_cell(input gp_t hi, input gp_t lo);
    return hi.g | (hi.p & lo.g);
  endfunction

endpackage

// File: rtl/shc_spec_prefix.sv
// Combinational carry network: exact Han-Carlson prefix for c, windowed sparse prefix for sc,
// and the speculation error flag. Position 0 of both trees carries cin; position i+1 is bit i.
module shc_spec_prefix
  import shc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SPEC_LEVELS = 3
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  input  logic             cin,
  output logic [WIDTH:0]   sc,
  output logic [WIDTH:0]   c,
  output logic             err
);

  localparam int W  = spec_window(SPEC_LEVELS);
  localparam int FL = $clog2(WIDTH + 1);

  gp_t [WIDTH:0]                pos;
  gp_t [FL:0][WIDTH:0]          ft;
  gp_t [SPEC_LEVELS:0][WIDTH:0] wt;

  always_comb begin
    pos[0].g = cin;
    pos[0].p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      pos[i+1].g = g[i];
      pos[i+1].p = p[i];
    end
  end

  // Odd columns pair up, run a Kogge-Stone tree among themselves, then even columns
  // take one grey cell from their odd neighbour below.
  always_comb begin
    ft = '0;
    for (int j = 0; j <= WIDTH; j++) begin
      if (j % 2 == 1) ft[0][j] = black_cell(pos[j], pos[j-1]);
      else            ft[0][j] = pos[j];
    end
    for (int m = 1; m <= FL; m++) begin
      for (int j = 0; j <= WIDTH; j++) begin
        if ((j % 2 == 1) && (j >= (1 << m))) ft[m][j] = black_cell(ft[m-1][j], ft[m-1][j-(1<<m)]);
        else                                 ft[m][j] = ft[m-1][j];
      end
    end
    c[0] = cin;
    for (int j = 1; j <= WIDTH; j++) begin
      if (j % 2 == 1) c[j] = ft[FL][j].g;
      else            c[j] = grey_cell(pos[j], ft[FL][j-1]);
    end
  end

  // Each doubling level widens the group ending at column j; after SPEC_LEVELS levels it
  // spans exactly W columns and never reaches below bit j-W.
  always_comb begin
    wt = '0;
    wt[0] = pos;
    for (int k = 0; k < SPEC_LEVELS; k++) begin
      for (int j = 0; j <= WIDTH; j++) begin
        if (j - (1 << k) >= 1) wt[k+1][j] = black_cell(wt[k][j], wt[k][j-(1<<k)]);
        else                   wt[k+1][j] = wt[k][j];
      end
    end
  end

  always_comb begin
    sc  = '0;
    err = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i <= W) begin
        sc[i] = c[i];
      end else begin
        sc[i] = wt[SPEC_LEVELS][i].g;
        err   = err | (wt[SPEC_LEVELS][i].p & c[i-W]);
      end
    end
  end

endmodule

// File: rtl/shc_varlat_adder.sv
// Variable-latency speculative adder with a registered valid/ready handshake.
// Define SHC_ERR_STATS_EN to add the saturating err_count correction counter.
module shc_varlat_adder
  import shc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SPEC_LEVELS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             corrected
`ifdef SHC_ERR_STATS_EN
  ,
  output logic [15:0]      err_count
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             corrected_q, corrected_d;

  logic [WIDTH-1:0] p, g;
  logic [WIDTH:0]   sc, c;
  logic             err;

  assign p = a_q ^ b_q;
  assign g = a_q & b_q;

  shc_spec_prefix #(.WIDTH(WIDTH), .SPEC_LEVELS(SPEC_LEVELS)) u_prefix (
    .p  (p),
    .g  (g),
    .cin(cin_q),
    .sc (sc),
    .c  (c),
    .err(err)
  );

  // NOTE: every combinational output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    corrected_d = corrected_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (err) begin
          state_d = S_CORR;
        end else begin
          sum_d       = p ^ sc[WIDTH-1:0];
          cout_d      = sc[WIDTH];
          corrected_d = 1'b0;
          state_d     = S_HOLD;
        end
      end
      S_CORR: begin
        sum_d       = p ^ c[WIDTH-1:0];
        cout_d      = c[WIDTH];
        corrected_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            cin_d   = cin;
            state_d = S_EVAL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      corrected_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      corrected_q <= corrected_d;
    end
  end

  // NOTE: operand registers carry no reset; they are only read after IDLE has loaded them.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    cin_q <= cin_d;
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign corrected = corrected_q;

`ifdef SHC_ERR_STATS_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (state_q == S_EVAL && err && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_shc_varlat_adder.sv
// Directed and random checks of shc_varlat_adder at WIDTH=16, SPEC_LEVELS=3 (window 8).
// Latency is counted in clock edges, the accepting edge being edge 1.
module tb_shc_varlat_adder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, corrected;
  logic [15:0] a, b, sum;
`ifdef SHC_ERR_STATS_EN
  logic [15:0] err_count;
`endif

  int n_cmp   = 0;
  int n_fail  = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  shc_varlat_adder #(.WIDTH(16), .SPEC_LEVELS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .corrected(corrected)
`ifdef SHC_ERR_STATS_EN
    ,
    .err_count(err_count)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        corr;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operand set once in_ready allows, then wait for the result.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                        output logic [15:0] rs, output logic rc, output logic rcorr,
                        output int lat);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    a = va; b = vb; cin = vcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; rcorr = corrected;
  endtask

  // Independent reference for the speculation error: carries recovered from the true sum.
  function automatic logic model_err(input logic [15:0] va, input logic [15:0] vb, input logic vcin);
    logic [16:0] s, cv;
    logic [15:0] pv;
    logic        e;
    s  = {1'b0, va} + {1'b0, vb} + {16'b0, vcin};
    pv = va ^ vb;
    cv = s ^ {1'b0, pv};
    e  = 1'b0;
    for (int i = 9; i <= 16; i++) if ((&pv[i-1 -: 8]) && cv[i-8]) e = 1'b1;
    return e;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rs, ra, rb;
    logic        rc, rcorr, rcin, e_corr;
    logic [16:0] full;
    int          lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 2};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 3};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 2};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 2};
    vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 2};
    vecs[6] = '{16'h01FF, 16'h0000, 1'b1, 16'h0200, 1'b0, 1'b1, 3};
    vecs[7] = '{16'hFF00, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 2};
    vecs[8] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready",  {31'b0, in_ready},  32'd1);
    check("reset_sum",       {16'b0, sum},       32'd0);
    check("reset_cout",      {31'b0, cout},      32'd0);
    check("reset_corrected", {31'b0, corrected}, 32'd0);
`ifdef SHC_ERR_STATS_EN
    check("reset_err_count", {16'b0, err_count}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, rcorr, lat);
      check($sformatf("vec%0d_sum", i),  {16'b0, rs},    {16'b0, vecs[i].sum});
      check($sformatf("vec%0d_cout", i), {31'b0, rc},    {31'b0, vecs[i].cout});
      check($sformatf("vec%0d_corr", i), {31'b0, rcorr}, {31'b0, vecs[i].corr});
      check($sformatf("vec%0d_lat", i),  lat,            vecs[i].lat);
      if (vecs[i].corr) exp_err++;
    end
`ifdef SHC_ERR_STATS_EN
    check("table_err_count", {16'b0, err_count}, exp_err);
`endif
    @(posedge clk); #1;

    // Back-to-back issue two edges apart with out_ready held high.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_first_eval_no_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("b2b_first_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_first_sum",   {16'b0, sum},       32'h0100);
    check("b2b_first_corr",  {31'b0, corrected}, 32'd0);
    check("b2b_hold_ready",  {31'b0, in_ready},  32'd1);
    a = 16'h1000; b = 16'h1000; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid_drops", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("b2b_second_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_second_sum",   {16'b0, sum},       32'h2000);
    check("b2b_second_corr",  {31'b0, corrected}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: result must hold steady while out_ready is low.
    out_ready = 1'b0;
    run_op(16'h1234, 16'h4321, 1'b0, rs, rc, rcorr, lat);
    check("bp_lat", lat, 2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_sum", k),       {16'b0, sum},       32'h5555);
      check($sformatf("bp%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp%0d_in_ready", k),  {31'b0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    check("bp_release_idle",      {31'b0, in_ready},  32'd1);

    // Reset while the corrective stage is active discards the operation.
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("corr_stage_no_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_sum",       {16'b0, sum},       32'd0);
    check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
`ifdef SHC_ERR_STATS_EN
    check("midrst_err_count", {16'b0, err_count}, 32'd0);
`endif
    rst_n = 1'b1;
    exp_err = 0;
    @(posedge clk); #1;
    check("midrst_discarded", {31'b0, out_valid}, 32'd0);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rcin = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {16'b0, rcin};
      e_corr = model_err(ra, rb, rcin);
      run_op(ra, rb, rcin, rs, rc, rcorr, lat);
      check($sformatf("rnd%0d_sum", n),  {16'b0, rs},    {16'b0, full[15:0]});
      check($sformatf("rnd%0d_cout", n), {31'b0, rc},    {31'b0, full[16]});
      check($sformatf("rnd%0d_corr", n), {31'b0, rcorr}, {31'b0, e_corr});
      check($sformatf("rnd%0d_lat", n),  lat,            e_corr ? 3 : 2);
      if (e_corr) exp_err++;
    end
`ifdef SHC_ERR_STATS_EN
    check("random_err_count", {16'b0, err_count}, exp_err);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
